// File: rtl/if_fetch_ctrl_if.sv
// Fetch-side bus of if_fetch_ctrl: ROM port, hazard/redirect inputs, IF/ID outputs.
// Each cycle the controller takes the ROM word for imem_addr. A redirect
// (branch_taken, then jump) beats stall. stall only freezes PC and IF/ID.
// None of these signals uses a valid/ready handshake.
interface if_fetch_ctrl_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        ifid_valid;
   logic [31:0] ifid_inst;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc_plus4;
   logic        halted;
   logic [1:0]  dbg_state;

   modport master (
      output imem_addr, ifid_valid, ifid_inst, ifid_pc, ifid_pc_plus4, halted, dbg_state,
      input  imem_inst, stall, branch_taken, branch_target, jump, jump_target
   );

   modport slave (
      input  imem_addr, ifid_valid, ifid_inst, ifid_pc, ifid_pc_plus4, halted, dbg_state,
      output imem_inst, stall, branch_taken, branch_target, jump, jump_target
   );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, fills IF/ID, arbitrates redirects and stalls,
// and parks the front end on a self-loop jump.
module if_fetch_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter bit          HALT_DETECT = 1'b1
) (
   input  logic          clk,
   input  logic          reset_n,
   if_fetch_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] plus4_q, plus4_d;
   logic        halted_q, halted_d;

   logic [31:0] pc_plus4;
   logic [31:0] br_tgt;
   logic [31:0] jmp_tgt;
   logic        load_bubble;

   assign pc_plus4 = pc_q + 32'd4;
   assign br_tgt   = {bus.branch_target[31:2], 2'b00};
   assign jmp_tgt  = {bus.jump_target[31:2], 2'b00};

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      valid_d     = valid_q;
      inst_d      = inst_q;
      ifid_pc_d   = ifid_pc_q;
      plus4_d     = plus4_q;
      halted_d    = halted_q;
      load_bubble = 1'b0;
      case (state_q)
         BOOT: begin
            load_bubble = 1'b1;
            state_d     = RUN;
         end
         RUN: begin
            if (bus.branch_taken) begin
               pc_d        = br_tgt;
               load_bubble = 1'b1;
            end else if (bus.jump) begin
               pc_d        = jmp_tgt;
               load_bubble = 1'b1;
               // A jump in ID that targets its own PC never makes progress: park.
               if (HALT_DETECT && valid_q && (jmp_tgt == ifid_pc_q)) begin
                  state_d  = HALT;
                  halted_d = 1'b1;
               end
            end else if (!bus.stall) begin
               pc_d      = pc_plus4;
               valid_d   = 1'b1;
               inst_d    = bus.imem_inst;
               ifid_pc_d = pc_q;
               plus4_d   = pc_plus4;
            end
         end
         HALT: begin
            load_bubble = 1'b1;
            // An older branch still in flight may pull the pipeline out of the loop.
            if (bus.branch_taken) begin
               pc_d     = br_tgt;
               state_d  = RUN;
               halted_d = 1'b0;
            end
         end
         default: begin
            load_bubble = 1'b1;
            state_d     = BOOT;
         end
      endcase
      if (load_bubble) begin
         valid_d   = 1'b0;
         inst_d    = 32'h0;
         ifid_pc_d = 32'h0;
         plus4_d   = 32'h0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= BOOT;
         pc_q      <= RESET_PC;
         valid_q   <= 1'b0;
         inst_q    <= 32'h0;
         ifid_pc_q <= 32'h0;
         plus4_q   <= 32'h0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         valid_q   <= valid_d;
         inst_q    <= inst_d;
         ifid_pc_q <= ifid_pc_d;
         plus4_q   <= plus4_d;
         halted_q  <= halted_d;
      end
   end

   assign bus.imem_addr     = pc_q;
   assign bus.ifid_valid    = valid_q;
   assign bus.ifid_inst     = inst_q;
   assign bus.ifid_pc       = ifid_pc_q;
   assign bus.ifid_pc_plus4 = plus4_q;
   assign bus.halted        = halted_q;
   assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: one halting instance and one with halt detection off.
module tb_if_fetch_ctrl;
   logic clk;
   logic reset_n;
   logic        stall_r, br_r, j_r;
   logic [31:0] brt_r, jt_r;
   logic [31:0] rom [0:255];
   int n_checks;
   int n_fail;

   if_fetch_ctrl_if bus ();
   if_fetch_ctrl_if bus_nh ();

   if_fetch_ctrl #(.RESET_PC(32'h0), .HALT_DETECT(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus));
   if_fetch_ctrl #(.RESET_PC(32'h0), .HALT_DETECT(1'b0)) dut_nh (
      .clk(clk), .reset_n(reset_n), .bus(bus_nh));

   assign bus.imem_inst        = rom[bus.imem_addr[9:2]];
   assign bus.stall            = stall_r;
   assign bus.branch_taken     = br_r;
   assign bus.branch_target    = brt_r;
   assign bus.jump             = j_r;
   assign bus.jump_target      = jt_r;
   assign bus_nh.imem_inst     = rom[bus_nh.imem_addr[9:2]];
   assign bus_nh.stall         = stall_r;
   assign bus_nh.branch_taken  = br_r;
   assign bus_nh.branch_target = brt_r;
   assign bus_nh.jump          = j_r;
   assign bus_nh.jump_target   = jt_r;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      stall_r = 1'b0; br_r = 1'b0; j_r = 1'b0; brt_r = 32'h0; jt_r = 32'h0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      clear_inputs();
      for (int i = 0; i < 256; i++) rom[i] = 32'hA500_0000 | (i << 2);
      rom[0] = 32'h2004_2f5b;
      rom[1] = 32'h2405_cfc7;
      step();
      step();
      n_checks++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", bus.imem_addr, 32'h0); end
      n_checks++; if (bus.ifid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.ifid_valid); end
      n_checks++; if (bus.ifid_inst !== 32'h0 || bus.ifid_pc !== 32'h0 || bus.ifid_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL reset_ifid: inst %h pc %h p4 %h want all 0", bus.ifid_inst, bus.ifid_pc, bus.ifid_pc_plus4); end
      n_checks++; if (bus.halted !== 1'b0 || bus.dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: halted %b state %0d want 0/BOOT", bus.halted, bus.dbg_state); end
   endtask

   task automatic test_boot_and_fetch();
      reset_n = 1'b1;
      step();
      n_checks++; if (bus.imem_addr !== 32'h0 || bus.ifid_valid !== 1'b0 || bus.dbg_state !== 2'd1) begin n_fail++; $display("FAIL boot_cycle: addr %h valid %b state %0d want 0/0/RUN", bus.imem_addr, bus.ifid_valid, bus.dbg_state); end
      step();
      n_checks++; if (bus.imem_addr !== 32'h4) begin n_fail++; $display("FAIL first_advance: got %h want 4", bus.imem_addr); end
      n_checks++; if (bus.ifid_valid !== 1'b1 || bus.ifid_inst !== 32'h2004_2f5b || bus.ifid_pc !== 32'h0 || bus.ifid_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL first_fetch: v %b inst %h pc %h p4 %h want 1/20042f5b/0/4", bus.ifid_valid, bus.ifid_inst, bus.ifid_pc, bus.ifid_pc_plus4); end
      step();
      n_checks++; if (bus.ifid_inst !== 32'h2405_cfc7 || bus.ifid_pc !== 32'h4 || bus.ifid_pc_plus4 !== 32'h8) begin n_fail++; $display("FAIL second_fetch: inst %h pc %h p4 %h want 2405cfc7/4/8", bus.ifid_inst, bus.ifid_pc, bus.ifid_pc_plus4); end
   endtask

   task automatic test_stall();
      step();
      step();
      n_checks++; if (bus.imem_addr !== 32'h10 || bus.ifid_pc !== 32'hC) begin n_fail++; $display("FAIL pre_stall: addr %h ifid_pc %h want 10/c", bus.imem_addr, bus.ifid_pc); end
      stall_r = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++; if (bus.imem_addr !== 32'h10 || bus.ifid_pc !== 32'hC || bus.ifid_inst !== 32'hA500_000C || bus.ifid_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold%0d: addr %h pc %h inst %h v %b want 10/c/a500000c/1", i, bus.imem_addr, bus.ifid_pc, bus.ifid_inst, bus.ifid_valid); end
      end
      stall_r = 1'b0;
      step();
      n_checks++; if (bus.imem_addr !== 32'h14 || bus.ifid_pc !== 32'h10 || bus.ifid_inst !== 32'hA500_0010) begin n_fail++; $display("FAIL stall_release: addr %h pc %h inst %h want 14/10/a5000010", bus.imem_addr, bus.ifid_pc, bus.ifid_inst); end
   endtask

   task automatic test_redirect_priority();
      br_r = 1'b1; brt_r = 32'h1F; stall_r = 1'b1; j_r = 1'b1; jt_r = 32'h40;
      step();
      clear_inputs();
      n_checks++; if (bus.imem_addr !== 32'h1C) begin n_fail++; $display("FAIL branch_target: got %h want 1c", bus.imem_addr); end
      n_checks++; if (bus.ifid_valid !== 1'b0 || bus.ifid_inst !== 32'h0 || bus.ifid_pc !== 32'h0) begin n_fail++; $display("FAIL branch_bubble: v %b inst %h pc %h want 0/0/0", bus.ifid_valid, bus.ifid_inst, bus.ifid_pc); end
      step();
      n_checks++; if (bus.ifid_valid !== 1'b1 || bus.ifid_inst !== 32'hA500_001C || bus.ifid_pc !== 32'h1C || bus.imem_addr !== 32'h20) begin n_fail++; $display("FAIL branch_resume: v %b inst %h pc %h addr %h want 1/a500001c/1c/20", bus.ifid_valid, bus.ifid_inst, bus.ifid_pc, bus.imem_addr); end
   endtask

   task automatic test_halt();
      for (int i = 0; i < 6; i++) step();
      n_checks++; if (bus.ifid_pc !== 32'h34 || bus_nh.ifid_pc !== 32'h34 || bus.imem_addr !== 32'h38) begin n_fail++; $display("FAIL pre_halt: pc %h nh_pc %h addr %h want 34/34/38", bus.ifid_pc, bus_nh.ifid_pc, bus.imem_addr); end
      for (int i = 0; i < 3; i++) begin
         j_r = 1'b1; jt_r = 32'h34;
         step();
         n_checks++; if (bus.halted !== 1'b1 || bus.imem_addr !== 32'h34 || bus.ifid_valid !== 1'b0 || bus.dbg_state !== 2'd2) begin n_fail++; $display("FAIL halt_jump%0d: halted %b addr %h v %b state %0d want 1/34/0/HALT", i, bus.halted, bus.imem_addr, bus.ifid_valid, bus.dbg_state); end
         n_checks++; if (bus_nh.halted !== 1'b0 || bus_nh.imem_addr !== 32'h34 || bus_nh.ifid_valid !== 1'b0) begin n_fail++; $display("FAIL nohalt_jump%0d: halted %b addr %h v %b want 0/34/0", i, bus_nh.halted, bus_nh.imem_addr, bus_nh.ifid_valid); end
         j_r = 1'b0;
         step();
         n_checks++; if (bus.halted !== 1'b1 || bus.imem_addr !== 32'h34 || bus.ifid_valid !== 1'b0) begin n_fail++; $display("FAIL halt_idle%0d: halted %b addr %h v %b want 1/34/0", i, bus.halted, bus.imem_addr, bus.ifid_valid); end
         n_checks++; if (bus_nh.halted !== 1'b0 || bus_nh.ifid_valid !== 1'b1 || bus_nh.ifid_pc !== 32'h34 || bus_nh.ifid_inst !== 32'hA500_0034 || bus_nh.imem_addr !== 32'h38) begin n_fail++; $display("FAIL nohalt_refetch%0d: h %b v %b pc %h inst %h addr %h want 0/1/34/a5000034/38", i, bus_nh.halted, bus_nh.ifid_valid, bus_nh.ifid_pc, bus_nh.ifid_inst, bus_nh.imem_addr); end
      end
      stall_r = 1'b1; j_r = 1'b1; jt_r = 32'h80;
      step();
      clear_inputs();
      n_checks++; if (bus.halted !== 1'b1 || bus.imem_addr !== 32'h34 || bus.ifid_valid !== 1'b0) begin n_fail++; $display("FAIL halt_ignores: halted %b addr %h v %b want 1/34/0", bus.halted, bus.imem_addr, bus.ifid_valid); end
   endtask

   task automatic test_halt_exit();
      br_r = 1'b1; brt_r = 32'h20;
      step();
      clear_inputs();
      n_checks++; if (bus.halted !== 1'b0 || bus.imem_addr !== 32'h20 || bus.dbg_state !== 2'd1 || bus.ifid_valid !== 1'b0) begin n_fail++; $display("FAIL halt_exit: halted %b addr %h state %0d v %b want 0/20/RUN/0", bus.halted, bus.imem_addr, bus.dbg_state, bus.ifid_valid); end
      step();
      n_checks++; if (bus.imem_addr !== 32'h24 || bus.ifid_pc !== 32'h20 || bus.ifid_valid !== 1'b1) begin n_fail++; $display("FAIL run_resume: addr %h pc %h v %b want 24/20/1", bus.imem_addr, bus.ifid_pc, bus.ifid_valid); end
   endtask

   task automatic test_wrap_and_async_reset();
      br_r = 1'b1; brt_r = 32'hFFFF_FFFC;
      step();
      clear_inputs();
      n_checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup: got %h want fffffffc", bus.imem_addr); end
      step();
      n_checks++; if (bus.imem_addr !== 32'h0 || bus.ifid_pc !== 32'hFFFF_FFFC || bus.ifid_pc_plus4 !== 32'h0 || bus.ifid_inst !== 32'hA500_03FC) begin n_fail++; $display("FAIL wrap: addr %h pc %h p4 %h inst %h want 0/fffffffc/0/a50003fc", bus.imem_addr, bus.ifid_pc, bus.ifid_pc_plus4, bus.ifid_inst); end
      step();
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++; if (bus.imem_addr !== 32'h0 || bus.ifid_valid !== 1'b0 || bus.ifid_inst !== 32'h0 || bus.dbg_state !== 2'd0) begin n_fail++; $display("FAIL async_reset: addr %h v %b inst %h state %0d want 0/0/0/BOOT", bus.imem_addr, bus.ifid_valid, bus.ifid_inst, bus.dbg_state); end
      n_checks++; if (bus_nh.ifid_valid !== 1'b0 || bus_nh.imem_addr !== 32'h0) begin n_fail++; $display("FAIL async_reset_nh: addr %h v %b want 0/0", bus_nh.imem_addr, bus_nh.ifid_valid); end
   endtask

   task automatic test_boot_ignores_inputs();
      step();
      reset_n = 1'b1;
      stall_r = 1'b1; br_r = 1'b1; brt_r = 32'h80; j_r = 1'b1; jt_r = 32'h90;
      step();
      clear_inputs();
      n_checks++; if (bus.imem_addr !== 32'h0 || bus.ifid_valid !== 1'b0 || bus.dbg_state !== 2'd1) begin n_fail++; $display("FAIL boot_ignore: addr %h v %b state %0d want 0/0/RUN", bus.imem_addr, bus.ifid_valid, bus.dbg_state); end
      step();
      n_checks++; if (bus.imem_addr !== 32'h4 || bus.ifid_inst !== 32'h2004_2f5b || bus.ifid_valid !== 1'b1) begin n_fail++; $display("FAIL boot_then_run: addr %h inst %h v %b want 4/20042f5b/1", bus.imem_addr, bus.ifid_inst, bus.ifid_valid); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_boot_and_fetch();
      test_stall();
      test_redirect_priority();
      test_halt();
      test_halt_exit();
      test_wrap_and_async_reset();
      test_boot_ignores_inputs();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Instruction-fetch controller for the 5-stage MIPS pipeline. It owns the PC and drives the address of the combinational instruction ROM (word index = address[9:2]). It captures the returned word into the IF/ID pipeline register. It arbitrates next-PC between sequential fetch, EX-stage branch redirect, ID-stage jump redirect and hazard-unit stall. It detects the terminal self-loop jump and parks the front end.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
HALT_DETECT, 1, 1 enables self-loop halt detection; 0 keeps the block in RUN forever.

Ports:
clk  in  1  pipeline clock, rising edge
reset_n  in  1  asynchronous active-low reset
imem_addr  out  32  instruction ROM address, equal to the PC register (combinational)
imem_inst  in  32  instruction ROM data, valid in the same cycle
stall  in  1  hazard unit: hold PC and IF/ID
branch_taken  in  1  EX-stage branch resolved taken
branch_target  in  32  EX-stage branch target
jump  in  1  ID-stage j/jal/jr decoded
jump_target  in  32  ID-stage jump target
ifid_valid  out  1  IF/ID holds a real instruction
ifid_inst  out  32  IF/ID instruction (32'h0 = nop when invalid)
ifid_pc  out  32  PC of ifid_inst
ifid_pc_plus4  out  32  ifid_pc + 4
halted  out  1  front end parked on self-loop

Behaviour:
- Reset (reset_n=0, asynchronous): PC=RESET_PC; state=BOOT; ifid_valid=0; ifid_inst=0; ifid_pc=0; ifid_pc_plus4=0; halted=0. If reset is asserted mid-operation, all registers clear immediately, regardless of clk.
- States: BOOT, RUN, HALT.
- BOOT:
  - Lasts exactly one cycle after reset release.
  - PC holds, IF/ID loads a bubble, all inputs are ignored.
  - Transitions to RUN.
- RUN, next-PC priority (highest first):
  1. branch_taken: PC <= {branch_target[31:2],2'b00}.
  2. jump: PC <= {jump_target[31:2],2'b00}.
  3. stall: PC holds.
  4. Otherwise: PC <= PC+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- RUN, IF/ID update:
  - If branch_taken or jump: load a bubble (valid=0, inst=0, pc=0, pc_plus4=0). A redirect overrides stall, and the wrong-path fetch is squashed. There are no delay slots.
  - Else if stall: IF/ID holds all fields.
  - Else: valid=1, inst=imem_inst, pc=PC, pc_plus4=PC+4.
  - Latency: the instruction at address A appears on ifid_* exactly one cycle after imem_addr=A with no stall.
  - Redirect penalty: a taken branch or jump produces exactly one bubble in IF/ID from this block.
- Halt detection (HALT_DETECT=1):
  - Condition: in RUN, jump=1, branch_taken=0, ifid_valid=1, and {jump_target[31:2],2'b00}==ifid_pc (self-loop).
  - Next state is HALT. PC <= that target. IF/ID loads a bubble. halted <= 1 on the same edge.
- HALT:
  - PC frozen; IF/ID held as bubble; halted=1.
  - stall, jump and branch_taken are ignored, except that branch_taken=1 leaves HALT to RUN with PC <= branch target and halted <= 0. This lets an older in-flight branch still win.
- stall and redirect in the same cycle: the redirect wins (see priority). stall in BOOT is ignored.
- branch_taken and jump in the same cycle: the branch wins. The jump is younger and wrong-path.

Test Plan:
1. Reset, release, ROM word0=0x20042f5b, word1=0x2405cfc7, no stall → imem_addr=0 for BOOT + 1 RUN cycle. Then ifid_inst=0x20042f5b, ifid_pc=0, ifid_pc_plus4=4, valid=1. Next cycle ifid_inst=0x2405cfc7, ifid_pc=4.
2. stall held 2 cycles at PC=0x10 → imem_addr stays 0x10 and IF/ID holds. On release, PC advances to 0x14.
3. branch_taken=1, branch_target=0x1F (misaligned) together with stall=1 and jump=1 (target 0x40) → PC=0x1C, one bubble (valid=0, inst=0), then the word at 0x1C.
4. ifid_pc=0x34, jump=1, jump_target=0x34 → halted=1 next edge, imem_addr frozen at 0x34, ifid_valid=0 for all further cycles. With HALT_DETECT=0, the same stimulus keeps re-fetching 0x34 with halted=0.
5. In HALT, assert branch_taken=1, branch_target=0x20 → halted=0, PC=0x20, RUN resumes.
6. PC=0xFFFF_FFFC, no stall → next imem_addr=0. Assert reset_n=0 mid-cycle → imem_addr=RESET_PC and ifid_valid=0 immediately, without a clock edge.
